// File: rtl/key_event_arbiter.sv
// Latches key press pulses as pending, grants them round-robin into a small event FIFO,
// and presents key indices over valid/ready. Optional drop counter: define KEY_ARB_DROP_CNT_EN.
module key_event_arbiter #(
    parameter int N_KEYS = 4,
    parameter int DEPTH  = 4,
    localparam int CW    = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_pulse,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CW-1:0]     evt_code,
    output logic              fifo_full,
    output logic [7:0]        drop_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]  DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [CW:0]  NKEYS_C = (CW+1)'(N_KEYS);
    localparam logic [CW-1:0] LAST_KEY = CW'(N_KEYS - 1);

    // Pending latches and round-robin pointer
    logic [N_KEYS-1:0] pend_q, pend_d;
    logic [CW-1:0]     rr_ptr_q, rr_ptr_d;

    // Event FIFO state
    logic [CW-1:0]     fifo_mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;

    // Arbiter results
    logic              gnt_valid;
    logic [CW-1:0]     gnt_idx;
    logic [CW:0]       scan_idx;
    logic [N_KEYS-1:0] gnt_oh;

    logic              push;
    logic              pop;

    // Search from rr_ptr upward with wrap; the registered count gates the grant so a
    // same-cycle pop never makes room for a push.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        if ((pend_q != '0) && (count_q < DEPTH_C)) begin
            for (int k = 0; k < N_KEYS; k++) begin
                scan_idx = {1'b0, rr_ptr_q} + (CW+1)'(k);
                if (scan_idx >= NKEYS_C) begin
                    scan_idx = scan_idx - NKEYS_C;
                end
                if (!gnt_valid && pend_q[scan_idx[CW-1:0]]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = scan_idx[CW-1:0];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_pend
            assign gnt_oh[gi] = gnt_valid && (gnt_idx == CW'(gi));
            // A fresh pulse re-arms the latch even when the old press is granted now.
            assign pend_d[gi] = (pend_q[gi] & ~gnt_oh[gi]) | key_pulse[gi];
        end
    endgenerate

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_valid) begin
            rr_ptr_d = (gnt_idx == LAST_KEY) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign push = gnt_valid;
    assign pop  = evt_valid && evt_ready;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q   <= '0;
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pend_q   <= pend_d;
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= gnt_idx;
        end
    end

    // Storage is never cleared, so the code is masked while the FIFO is empty.
    assign evt_valid = (count_q != '0);
    assign evt_code  = evt_valid ? fifo_mem[rd_ptr_q] : '0;
    assign fifo_full = (count_q == DEPTH_C);

`ifdef KEY_ARB_DROP_CNT_EN
    logic [N_KEYS-1:0] drop_vec;
    logic [15:0]       drop_sum;
    logic [15:0]       drop_tot;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    generate
        for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_drop
            assign drop_vec[gi] = key_pulse[gi] & pend_q[gi] & ~gnt_oh[gi];
        end
    endgenerate

    always_comb begin
        drop_sum = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            drop_sum = drop_sum + 16'(drop_vec[k]);
        end
        drop_tot   = {8'h00, drop_cnt_q} + drop_sum;
        drop_cnt_d = (drop_tot > 16'd255) ? 8'hFF : drop_tot[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= 8'h00;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 8'h00;
`endif

endmodule
